// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and window bit-index helper for the
// layer-1 convolution window sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package conv_pkg;

  localparam int F             = 28;      // feature width/height, must be even
  localparam int B             = 8;       // pixel width
  localparam int K             = 3;       // kernel size, fixed
  localparam int OF            = F / 2;   // stride-2 output size
  localparam int WIN_PER_FRAME = OF * OF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // LSB position of window element (wr,wc) in the flattened window bus.
  function automatic int win_idx(input int wr, input int wc);
    return (wr * K + wc) * B;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: an F-deep, B-wide shift register advanced on en.
// Latency: dout is the sample written DEPTH enables earlier (exactly one image row).
// Backpressure: none; the owner gates en with its pixel handshake.
// Ports: clk, rst (sync, high), clr (sync frame clear), en (shift), din, dout.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = F,
  parameter int W     = B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [DEPTH];

  // Clearing at frame start makes rows above the image read as zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_l1_window_ctrl.sv
// Layer-1 conv sequencer: raster pixels in, zero-padded (top/left) stride-2 3x3 windows out, 196 per frame.
// Latency: a window is presented one cycle after the handshake of its bottom-right pixel (odd row, odd col).
// Backpressure: a stalled window holds o_window/o_window_valid and drops o_pixel_ready until it is taken.
// Ports: i_clk, i_rst (sync, high), i_start, i_pixel/i_pixel_valid/o_pixel_ready,
//        o_window/o_window_valid/i_window_ready, o_busy, o_frame_done.
// Optional build macro CONV_CTRL_PERF_EN adds o_stall_cnt (saturating count of stalled RUN cycles).
module conv_l1_window_ctrl
  import conv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [B-1:0]     i_pixel,
  input  logic             i_pixel_valid,
  output logic             o_pixel_ready,
  output logic [K*K*B-1:0] o_window,
  output logic             o_window_valid,
  input  logic             i_window_ready,
  output logic             o_busy,
  output logic             o_frame_done
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [15:0]      o_stall_cnt
`endif
);

  localparam logic [4:0] COL_LAST  = 5'(F - 1);
  localparam logic [9:0] PIX_TOTAL = 10'(F * F);
  localparam logic [7:0] WIN_LAST  = 8'(WIN_PER_FRAME - 1);

  state_t           state;
  logic [4:0]       row;
  logic [4:0]       col;
  logic [9:0]       pix_cnt;
  logic [7:0]       win_cnt;
  logic [B-1:0]     win     [K][K];   // [wr][wc], wr=0 is the oldest row
  logic [B-1:0]     win_nxt [K][K];
  logic [K*K*B-1:0] win_flat;
  logic [B-1:0]     lb1_dout;         // row r-1
  logic [B-1:0]     lb2_dout;         // row r-2
  logic             pix_hs;
  logic             win_hs;
  logic             start_frame;

  assign start_frame   = (state == IDLE) && i_start;
  assign o_pixel_ready = (state == RUN) && !(o_window_valid && !i_window_ready)
                         && (pix_cnt < PIX_TOTAL);
  assign pix_hs        = i_pixel_valid && o_pixel_ready;
  assign win_hs        = o_window_valid && i_window_ready;

  conv_line_buffer #(.DEPTH(F), .W(B)) u_lb1 (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (start_frame),
    .en   (pix_hs),
    .din  (i_pixel),
    .dout (lb1_dout)
  );

  conv_line_buffer #(.DEPTH(F), .W(B)) u_lb2 (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (start_frame),
    .en   (pix_hs),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // Window after this pixel: shift columns left, new column on the right.
  // At col 0 the middle column stands for col -1 (left padding) and is zeroed.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) win_nxt[r][c] = win[r][c];
    end
    for (int r = 0; r < K; r++) begin
      win_nxt[r][0] = (col == '0) ? '0 : win[r][1];
      win_nxt[r][1] = (col == '0) ? '0 : win[r][2];
    end
    win_nxt[0][2] = lb2_dout;
    win_nxt[1][2] = lb1_dout;
    win_nxt[2][2] = i_pixel;
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign win_flat[win_idx(r, c) +: B] = win_nxt[r][c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      o_busy         <= 1'b0;
      o_frame_done   <= 1'b0;
      o_window       <= '0;
      o_window_valid <= 1'b0;
      row            <= '0;
      col            <= '0;
      pix_cnt        <= '0;
      win_cnt        <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win[r][c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= RUN;
            o_busy  <= 1'b1;
            row     <= '0;
            col     <= '0;
            pix_cnt <= '0;
            win_cnt <= '0;
          end
        end
        RUN: begin
          if (win_hs && (win_cnt == WIN_LAST)) begin
            state        <= DONE;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          o_frame_done <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b0;
        end
      endcase

      if (pix_hs) begin
        win     <= win_nxt;
        pix_cnt <= pix_cnt + 10'd1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end

      if (win_hs) win_cnt <= win_cnt + 8'd1;

      // A new emission may coincide with the handshake of the previous window;
      // it simply replaces it, so there is no bubble.
      if (pix_hs && row[0] && col[0]) begin
        o_window       <= win_flat;
        o_window_valid <= 1'b1;
      end else if (win_hs) begin
        o_window_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || start_frame) begin
      o_stall_cnt <= '0;
    end else if ((state == RUN) && o_window_valid && !i_window_ready
                 && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
